// File: rtl/fft_twf_pkg.sv
// Shared types and constants for the CBFP 512-point FFT twiddle sequencers.
package fft_twf_pkg;

  localparam int TW_W  = 9;
  localparam int TW_AW = 6;
  localparam int FFT_N = 512;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } twf_t;

  typedef enum logic {IDLE, RUN} seq_state_e;

endpackage

// File: rtl/frame_idx_cnt.sv
// In-frame sample index counter with load-zero and wrap; shared by the stage sequencers.
module frame_idx_cnt #(
  parameter int LEN = 512,
  localparam int IW = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          clr,
  output logic [IW-1:0] idx,
  output logic          first,
  output logic          last
);

  logic [IW-1:0] idx_q;

  // idx is the index the current sample uses; clr restarts the frame at zero.
  assign idx   = clr ? '0 : idx_q;
  assign first = (idx == '0);
  assign last  = (idx == IW'(LEN - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q <= '0;
    end else if (en) begin
      idx_q <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/twf_m1_seq.sv
// Stage-m1 twiddle ROM sequencer: pairs each framed sample with its twiddle one cycle later.
// Optional statistics counters are enabled by defining TWF_M1_SEQ_STAT_EN.
module twf_m1_seq
  import fft_twf_pkg::*;
#(
  parameter int DW         = 16,
  parameter int FRAME_LEN  = FFT_N,
  parameter int ADDR_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic [DW-1:0]     in_re,
  input  logic [DW-1:0]     in_im,
  output logic [TW_AW-1:0]  rom_addr,
  input  logic [TW_W-1:0]   rom_re,
  input  logic [TW_W-1:0]   rom_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DW-1:0]     out_re,
  output logic [DW-1:0]     out_im,
  output logic [TW_W-1:0]   out_tw_re,
  output logic [TW_W-1:0]   out_tw_im,
  output logic              sop_err,
  output logic              drop
`ifdef TWF_M1_SEQ_STAT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int IW = $clog2(FRAME_LEN);

  seq_state_e       state;
  logic             accept;
  logic             discard;
  logic             sop_ev;
  logic [IW-1:0]    idx;
  logic             first;
  logic             last;
  logic [TW_AW-1:0] addr_now;
  logic [TW_AW-1:0] addr_q;
  twf_t             tw;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign discard  = accept & (state == IDLE) & ~in_sop;
  assign sop_ev   = accept & (state == RUN) & in_sop;

  frame_idx_cnt #(.LEN(FRAME_LEN)) u_idx (
    .clk   (clk),
    .rstn  (rstn),
    .en    (accept & ~discard),
    .clr   (in_sop),
    .idx   (idx),
    .first (first),
    .last  (last)
  );

  // Outside the accept cycle the address is held so the ROM output stays valid under stall.
  assign addr_now = TW_AW'(idx >> ADDR_SHIFT);
  assign rom_addr = accept ? addr_now : addr_q;

  assign tw        = '{re: rom_re, im: rom_im};
  assign out_tw_re = tw.re;
  assign out_tw_im = tw.im;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      sop_err   <= 1'b0;
      drop      <= 1'b0;
      addr_q    <= '0;
    end else begin
      drop <= discard;
      if (sop_ev) begin
        sop_err <= 1'b1;
      end
      if (accept) begin
        addr_q    <= addr_now;
        out_valid <= ~discard;
        if (!discard) begin
          out_re  <= in_re;
          out_im  <= in_im;
          out_sop <= first;
          out_eop <= last;
          state   <= last ? IDLE : RUN;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef TWF_M1_SEQ_STAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (out_valid && out_ready && out_eop && frame_cnt != 16'hFFFF) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if ((discard || sop_ev) && err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_twf_m1_seq.sv
// Scoreboard bench for twf_m1_seq with a behavioural registered twiddle ROM.
module tb_twf_m1_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        inValid = 1'b0;
  logic        inSop = 1'b0;
  logic [15:0] inRe = '0;
  logic [15:0] inIm = '0;
  logic        outReady = 1'b1;
  logic        in_ready;
  logic [5:0]  rom_addr;
  logic [8:0]  romRe = '0;
  logic [8:0]  romIm = '0;
  logic        out_valid, out_sop, out_eop, sop_err, drop;
  logic [15:0] out_re, out_im;
  logic [8:0]  out_tw_re, out_tw_im;
`ifdef TWF_M1_SEQ_STAT_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  int nCompared = 0;
  int nMismatched = 0;
  logic [51:0] expQ[$];
  int  seqNo = 0;
  bit  mRun = 1'b0;
  int  mIdx = 0;
  int  dropSeen = 0;
  bit  gapCheck = 1'b0;

  twf_m1_seq dut (
    .clk(clk), .rstn(rstn),
    .in_valid(inValid), .in_ready(in_ready), .in_sop(inSop),
    .in_re(inRe), .in_im(inIm),
    .rom_addr(rom_addr), .rom_re(romRe), .rom_im(romIm),
    .out_valid(out_valid), .out_ready(outReady),
    .out_sop(out_sop), .out_eop(out_eop),
    .out_re(out_re), .out_im(out_im),
    .out_tw_re(out_tw_re), .out_tw_im(out_tw_im),
    .sop_err(sop_err), .drop(drop)
`ifdef TWF_M1_SEQ_STAT_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Twiddle table: the test-plan entries are fixed, the rest are distinct filler values.
  function automatic logic [17:0] romVal(input logic [5:0] a);
    case (a)
      6'd6:    return {9'd128, 9'd0};
      6'd9:    return {9'd118, 9'h1CF};
      6'd12:   return {9'd0,   9'h180};
      default: return {{2'b00, a, 1'b0}, 9'd0 - {3'b000, a}};
    endcase
  endfunction

  always @(posedge clk) {romRe, romIm} <= romVal(rom_addr);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one sample, wait (bounded) for acceptance and push its expected output.
  task automatic applyStimulus(input bit sop);
    int waited = 0;
    int useIdx;
    logic [5:0] addr;
    bit eop;
    inValid = 1'b1;
    inSop   = sop;
    inRe    = seqNo[15:0];
    inIm    = seqNo[15:0] ^ 16'hA5A5;
    seqNo++;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
    end else if (!mRun && !sop) begin
      checkOutput("drop_rom_addr", 64'(rom_addr), 64'd0);
    end else begin
      useIdx = sop ? 0 : mIdx;
      eop    = (useIdx == 511);
      addr   = useIdx[5:0];
      checkOutput("rom_addr", 64'(rom_addr), 64'(addr));
      expQ.push_back({inRe, inIm, sop, eop, romVal(addr)});
      mIdx = eop ? 0 : useIdx + 1;
      mRun = !eop;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    inValid = 1'b0;
    inSop   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    int cycle = 0;
    int lastEopCycle = -10;
    logic [51:0] act;
    forever begin
      @(negedge clk);
      cycle++;
      if (drop) dropSeen++;
      if (rstn && out_valid && outReady) begin
        act = {out_re, out_im, out_sop, out_eop, out_tw_re, out_tw_im};
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpected_out: got 0x%0h expected no output", act);
        end else begin
          checkOutput("out_beat", 64'(act), 64'(expQ.pop_front()));
        end
        if (gapCheck && out_sop) begin
          checkOutput("btb_gap", 64'(cycle - lastEopCycle), 64'd1);
          gapCheck = 1'b0;
        end
        if (out_eop) lastEopCycle = cycle;
      end
    end
  end

  initial begin : main
    int d0;
    #12;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_rom_addr", 64'(rom_addr), 64'd0);
    checkOutput("rst_outs", 64'({out_valid, out_sop, out_eop, sop_err, drop}), 64'd0);
    checkOutput("rst_data", 64'({out_re, out_im}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Frame A: plain frame, spot-check twiddles at idx 9 and 70.
    for (int i = 0; i < 512; i++) begin
      applyStimulus(i == 0);
      if (i == 9)  checkOutput("tw_idx9",  64'({out_tw_re, out_tw_im}), 64'({9'd118, 9'h1CF}));
      if (i == 70) checkOutput("tw_idx70", 64'({out_tw_re, out_tw_im}), 64'({9'd128, 9'd0}));
    end

    // Frame B: downstream stalls two cycles while idx 12 sits in the output register.
    for (int i = 0; i < 512; i++) begin
      if (i == 13) begin
        outReady = 1'b0;
        inValid  = 1'b1;
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
          checkOutput("stall_tw", 64'({out_tw_re, out_tw_im}), 64'({9'd0, 9'h180}));
          checkOutput("stall_addr", 64'(rom_addr), 64'd12);
          @(posedge clk);
          #1;
        end
        outReady = 1'b1;
      end
      applyStimulus(i == 0);
    end
    idleCycles(2);
    checkOutput("sop_err_clean", 64'(sop_err), 64'd0);

    // Three orphan samples in IDLE.
    d0 = dropSeen;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0);
    idleCycles(3);
    checkOutput("drop_count", 64'(dropSeen - d0), 64'd3);
    checkOutput("drop_no_out", 64'(out_valid), 64'd0);

    // Frame C: in_sop at idx 100 truncates and restarts the frame.
    for (int i = 0; i < 100; i++) applyStimulus(i == 0);
    applyStimulus(1'b1);
    checkOutput("sop_err_set", 64'(sop_err), 64'd1);
    checkOutput("restart_sop", 64'(out_sop), 64'd1);
    for (int i = 1; i < 512; i++) applyStimulus(1'b0);

    // Frames D and E back to back.
    for (int i = 0; i < 512; i++) applyStimulus(i == 0);
    gapCheck = 1'b1;
    for (int i = 0; i < 512; i++) applyStimulus(i == 0);
    idleCycles(2);
    checkOutput("btb_gap_seen", 64'(gapCheck), 64'd0);
`ifdef TWF_M1_SEQ_STAT_EN
    checkOutput("frame_cnt", 64'(frame_cnt), 64'd5);
    checkOutput("err_cnt", 64'(err_cnt), 64'd4);
`endif

    // Frame F: asynchronous reset at idx 300.
    for (int i = 0; i < 300; i++) applyStimulus(i == 0);
    inValid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checkOutput("mid_rst_outs", 64'({out_valid, out_sop, out_eop, sop_err, drop}), 64'd0);
    checkOutput("mid_rst_data", 64'({out_re, out_im}), 64'd0);
    checkOutput("mid_rst_addr", 64'(rom_addr), 64'd0);
    checkOutput("mid_rst_ready", 64'(in_ready), 64'd1);
    expQ.delete();
    mRun = 1'b0;
    mIdx = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Frame G: restart after reset begins at address 0.
    for (int i = 0; i < 5; i++) applyStimulus(i == 0);
    idleCycles(3);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/twf_m1_seq.md
# twf_m1_seq

Sequencer for the stage-m1 twiddle ROM (64 entries, 6-bit address, 9-bit signed re/im, 1-cycle registered read) in the CBFP 512-point FFT.
- Accepts a framed sample stream and generates the ROM address for each sample from its in-frame index.
- Delays the sample by the ROM latency so each sample leaves paired with its twiddle.
- Handles ready/valid backpressure, frame delimiting and framing errors.
- Sits between the preceding butterfly stage and the m1 twiddle multiplier.

## Interface
Parameters:
- DW, 16, sample re/im width (signed)
- FRAME_LEN, 512, samples per frame (power of two, ≥64)
- ADDR_SHIFT, 0, right shift applied to in-frame index before truncation to 6-bit address

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  input accept
- in_sop  in  1  first sample of frame, qualified by in_valid
- in_re, in_im  in  DW each  input sample
- rom_addr  out  6  address to twiddle ROM
- rom_re, rom_im  in  9 each  ROM registered output (signed)
- out_valid  out  1  output valid
- out_ready  in  1  downstream accept
- out_sop, out_eop  out  1 each  frame first/last sample markers
- out_re, out_im  out  DW each  delayed sample
- out_tw_re, out_tw_im  out  9 each  twiddle paired with out sample
- sop_err  out  1  sticky: in_sop seen mid-frame; cleared only by reset
- drop  out  1  one-cycle pulse: sample discarded in IDLE

## Operation
- Transfer on a port occurs when valid & ready are both high in the same cycle.
- in_ready = ~out_valid | out_ready (1-deep output register).
- The index counter idx spans 0..FRAME_LEN-1.
- rom_addr = ((idx_next >> ADDR_SHIFT) mod 64) in the accept cycle; otherwise rom_addr = addr_q, the address of the last accepted sample. This holds the ROM output stable during stalls.
- FSM states and transitions:
  - IDLE:
    - Accepted sample with in_sop → RUN. Sample uses idx 0 and idx becomes 1.
    - Accepted sample without in_sop is discarded, drop=1, no output generated.
  - RUN:
    - Each accepted sample uses the current idx, then idx increments.
    - Sample with idx = FRAME_LEN-1 gets out_eop; state returns to IDLE and idx returns to 0.
    - in_sop in RUN: sop_err set. Sample treated as idx 0 of a new frame with out_sop=1. No eop is issued for the truncated frame.
  - After eop, an in_sop on the next sample keeps frames back-to-back with no bubble.
- Output register loads out_re/out_im/out_sop/out_eop on accept.
- out_tw_re/out_tw_im = rom_re/rom_im pass-through; correct because the ROM saw the same address one cycle earlier and holds it under stall.
- No arithmetic on data; widths unchanged.

## Timing
- Latency: sample accepted in cycle t appears on out_* in cycle t+1 with its twiddle.
- Throughput: 1 sample/cycle when out_ready is held high.
- Stall: out_valid & ~out_ready freezes all outputs, addr_q, idx and FSM; in_ready=0.
- Reset values:
  - in_ready=1 (after release).
  - rom_addr=0.
  - out_valid, out_sop, out_eop, sop_err and drop all 0.
  - out_re/out_im=0; state IDLE; idx=0; addr_q=0.
- Reset mid-frame aborts the frame immediately; no partial eop is emitted.
- Simultaneous out transfer and new accept: output register reloads in the same cycle.

## Configuration
- TWF_M1_SEQ_STAT_EN defined:
  - Adds 16-bit outputs frame_cnt (count of completed frames, i.e. eop transfers) and err_cnt (count of sop_err events plus drops).
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package fft_twf_pkg holds:
  - constants TW_W=9, TW_AW=6 and FFT_N=512;
  - typedef twf_t (signed [TW_W-1:0] re/im struct);
  - enum seq_state_e {IDLE, RUN}.
- One natural sub-module, frame_idx_cnt:
  - index counter with load-zero and wrap;
  - flags first/last;
  - reused by other stage sequencers.

## Test plan
- Reset, then a 512-sample frame with in_sop on sample 0 and out_ready=1 → idx 9 gives rom_addr 9 and out_tw=(118,-49); idx 70 gives addr 6, tw=(128,0); out_eop on sample 511; state returns to IDLE.
- Same frame with out_ready toggled 1,0,0,1 around idx 12 → out_tw holds (0,-128) through the stall; no sample lost or duplicated; in_ready=0 while stalled.
- Three samples without in_sop in IDLE → drop pulses 3 times; out_valid stays 0.
- in_sop at idx 100 of a running frame → sop_err=1; that sample exits with out_sop=1 and addr 0; no eop for the truncated frame.
- Two back-to-back frames → second out_sop immediately follows the first out_eop with no gap; with TWF_M1_SEQ_STAT_EN, frame_cnt=2.
- rstn asserted at idx 300 → all outputs return to reset values asynchronously; next in_sop restarts the frame at addr 0.
